// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl_debounce
//   Single-button front end: 2-flop synchronizer, stability counter and a
//   debounced level. Emits a one-cycle press pulse on each accepted 0->1
//   change of the debounced level.
//   Ports:
//     clk, rst  - system clock, synchronous active-high reset
//     btn_i     - raw asynchronous, bouncy button
//     press_o   - one-cycle pulse per accepted press
//
// cpu_run_ctrl
//   Run/step/breakpoint controller for the openmips core. Generates the CPU
//   advance enable from the run/stop and single-step buttons plus a PC-match
//   breakpoint, latches the most recent write-back value for the display and
//   counts enabled CPU cycles.
//   Ports:
//     clk, rst      - system clock, synchronous active-high reset
//     btn_run       - raw run/stop toggle button
//     btn_step      - raw single-step button
//     bp_en         - breakpoint enable
//     bp_addr       - breakpoint instruction address
//     pc_i          - current CPU fetch address
//     wb_wdata_i    - CPU write-back data
//     cpu_ce_o      - CPU advance enable
//     disp_data_o   - latched write-back value
//     instr_cnt_o   - count of enabled CPU cycles (wraps)
//     state_o       - FSM state: 00 HALT, 01 RUN, 10 STEP, 11 BREAK
//     halted_o      - 1 in HALT or BREAK

module cpu_run_ctrl_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q, sync_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            arm_q, arm_d;
  logic            press_q, press_d;

  always_comb begin
    sync_d  = {sync_q[0], btn_i};
    cnt_d   = cnt_q;
    level_d = level_q;
    arm_d   = arm_q;
    press_d = 1'b0;

    if (sync_q[1] != level_q) begin
      if (cnt_q == DB_LAST) begin
        cnt_d   = '0;
        level_d = ~level_q;
        press_d = ~level_q & arm_q;
      end else begin
        cnt_d = cnt_q + DB_W'(1);
      end
    end else begin
      cnt_d = '0;
    end

    // A press only counts once the button has been seen released since
    // reset, so a button held through reset cannot fire a pulse.
    if (!level_q && !sync_q[1]) begin
      arm_d = 1'b1;
    end
  end

  // The synchronizer only carries the raw pin; it is left out of reset so
  // that a button held through reset is still seen as held afterwards.
  always_ff @(posedge clk) begin
    sync_q <= sync_d;
    if (rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      arm_q   <= 1'b0;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      arm_q   <= arm_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

module cpu_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_run,
  input  logic             btn_step,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      wb_wdata_i,
  output logic             cpu_ce_o,
  output logic [31:0]      disp_data_o,
  output logic [CNT_W-1:0] instr_cnt_o,
  output logic [1:0]       state_o,
  output logic             halted_o
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_BREAK = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic             bp_mask_q, bp_mask_d;
  logic             ce_dly_q, ce_dly_d;
  logic [31:0]      disp_q, disp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic run_p;
  logic step_p;
  logic hit;
  logic cpu_ce;

  cpu_run_ctrl_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_db_run (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn_run),
    .press_o (run_p)
  );

  cpu_run_ctrl_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_db_step (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn_step),
    .press_o (step_p)
  );

  always_comb begin
    // The compare is combinational so the matching instruction is held off
    // in the very cycle its address appears. The mask lets a resumed run
    // execute that instruction once without re-triggering.
    hit    = bp_en && (pc_i == bp_addr) && !bp_mask_q;
    cpu_ce = ((state_q == ST_RUN) && !hit) || (state_q == ST_STEP);

    state_d = state_q;
    case (state_q)
      ST_HALT: begin
        if (run_p)       state_d = ST_RUN;
        else if (step_p) state_d = ST_STEP;
      end
      ST_RUN: begin
        if (run_p)    state_d = ST_HALT;
        else if (hit) state_d = ST_BREAK;
      end
      ST_STEP: begin
        // One enabled cycle only; pulses arriving here are dropped.
        state_d = ST_HALT;
      end
      ST_BREAK: begin
        if (run_p)       state_d = ST_RUN;
        else if (step_p) state_d = ST_STEP;
      end
      default: state_d = ST_HALT;
    endcase

    bp_mask_d = bp_mask_q;
    if (cpu_ce) begin
      bp_mask_d = 1'b0;
    end
    if ((state_q == ST_BREAK) && (state_d != ST_BREAK)) begin
      bp_mask_d = 1'b1;
    end

    // Write-back data for an enabled cycle arrives one cycle later.
    ce_dly_d = cpu_ce;
    disp_d   = ce_dly_q ? wb_wdata_i : disp_q;
    cnt_d    = cpu_ce ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_HALT;
      bp_mask_q <= 1'b0;
      ce_dly_q  <= 1'b0;
      disp_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      bp_mask_q <= bp_mask_d;
      ce_dly_q  <= ce_dly_d;
      disp_q    <= disp_d;
      cnt_q     <= cnt_d;
    end
  end

  assign cpu_ce_o    = cpu_ce;
  assign disp_data_o = disp_q;
  assign instr_cnt_o = cnt_q;
  assign state_o     = state_q;
  assign halted_o    = (state_q == ST_HALT) || (state_q == ST_BREAK);

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Testbench for cpu_run_ctrl with DEBOUNCE_CYCLES=4 and a 16-bit counter.
// A cycle-level reference model tracks buttons, FSM, mask, counter and the
// display latch; scenario tasks compare the DUT against it and constants.

module tb_cpu_run_ctrl;

  localparam int D      = 4;
  localparam int S_HALT = 0;
  localparam int S_RUN  = 1;
  localparam int S_STEP = 2;
  localparam int S_BRK  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_run;
  logic        btn_step;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] pc_i;
  logic [31:0] wb_wdata_i;
  logic        cpu_ce_o;
  logic [31:0] disp_data_o;
  logic [15:0] instr_cnt_o;
  logic [1:0]  state_o;
  logic        halted_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_run     (btn_run),
    .btn_step    (btn_step),
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
    .pc_i        (pc_i),
    .wb_wdata_i  (wb_wdata_i),
    .cpu_ce_o    (cpu_ce_o),
    .disp_data_o (disp_data_o),
    .instr_cnt_o (instr_cnt_o),
    .state_o     (state_o),
    .halted_o    (halted_o)
  );

  // Reference model state. Index 0 = run button, 1 = step button.
  int          m_state = S_HALT;
  bit          m_mask  = 0;
  int          m_cnt   = 0;
  logic [31:0] m_disp  = '0;
  bit          m_ce_d  = 0;
  bit          b_hist0 [2] = '{0, 0};
  bit          b_hist1 [2] = '{0, 0};
  bit          b_level [2] = '{0, 0};
  bit          b_armed [2] = '{0, 0};
  bit          b_pulse [2] = '{0, 0};
  int          b_run   [2] = '{0, 0};
  bit          pc_track = 0;

  function automatic bit m_hit();
    return bp_en && (pc_i == bp_addr) && !m_mask;
  endfunction

  function automatic bit m_ce();
    return ((m_state == S_RUN) && !m_hit()) || (m_state == S_STEP);
  endfunction

  // Advance the model across one clock edge using the inputs as they stand,
  // then wait for that edge.
  task automatic adv();
    bit hit, ce, pr, ps, s, lv;
    bit raw [2];
    int nxt;
    hit = m_hit();
    ce  = m_ce();
    pr  = b_pulse[0];
    ps  = b_pulse[1];
    raw[0] = btn_run;
    raw[1] = btn_step;
    if (rst) begin
      m_state = S_HALT; m_mask = 0; m_cnt = 0; m_disp = '0; m_ce_d = 0;
      for (int b = 0; b < 2; b++) begin
        b_level[b] = 0; b_armed[b] = 0; b_pulse[b] = 0; b_run[b] = 0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        s  = b_hist1[b];
        lv = b_level[b];
        b_pulse[b] = 0;
        if (s != lv) begin
          b_run[b]++;
          if (b_run[b] == D) begin
            b_level[b] = !lv;
            b_run[b]   = 0;
            b_pulse[b] = !lv && b_armed[b];
          end
        end else begin
          b_run[b] = 0;
        end
        if (!lv && !s) b_armed[b] = 1;
      end
      nxt = m_state;
      if (m_state == S_HALT || m_state == S_BRK) begin
        if (pr) nxt = S_RUN;
        else if (ps) nxt = S_STEP;
      end else if (m_state == S_RUN) begin
        if (pr) nxt = S_HALT;
        else if (hit) nxt = S_BRK;
      end else begin
        nxt = S_HALT;
      end
      if (ce) m_mask = 0;
      if (m_state == S_BRK && nxt != S_BRK) m_mask = 1;
      if (m_ce_d) m_disp = wb_wdata_i;
      m_ce_d  = ce;
      m_cnt   = (m_cnt + int'(ce)) % 65536;
      m_state = nxt;
    end
    for (int b = 0; b < 2; b++) begin
      b_hist1[b] = b_hist0[b];
      b_hist0[b] = raw[b];
    end
    @(posedge clk);
    #1;
    if (pc_track) pc_i = 32'(m_cnt) << 2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) adv();
  endtask

  task automatic do_reset();
    rst = 1'b1; btn_run = 1'b0; btn_step = 1'b0; bp_en = 1'b0;
    bp_addr = '0; pc_track = 0; pc_i = '0;
    idle(2);
    rst = 1'b0;
    idle(6);
  endtask

  task automatic test_reset();
    int bad_ce;
    bad_ce = 0;
    rst = 1'b1; btn_run = 1'b0; btn_step = 1'b0; bp_en = 1'b0;
    bp_addr = '0; pc_i = '0; wb_wdata_i = '0;
    idle(3);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cpu_ce_o !== 1'b0) bad_ce++;
      adv();
    end
    @(negedge clk);
    n_checks++;
    if (bad_ce != 0) $display("FAIL reset_idle_ce: got %0d enabled cycles, want 0", bad_ce);
    else n_pass++;
    n_checks++;
    if (state_o !== 2'b00) $display("FAIL reset_state: got %0d want 0", state_o);
    else n_pass++;
    n_checks++;
    if (instr_cnt_o !== 16'h0) $display("FAIL reset_cnt: got %0h want 0", instr_cnt_o);
    else n_pass++;
    n_checks++;
    if (halted_o !== 1'b1) $display("FAIL reset_halted: got %0b want 1", halted_o);
    else n_pass++;
    n_checks++;
    if (disp_data_o !== 32'h0) $display("FAIL reset_disp: got %0h want 0", disp_data_o);
    else n_pass++;
  endtask

  task automatic test_step();
    int pulses, model_bad, seen_run;
    pulses = 0; model_bad = 0; seen_run = 0;
    do_reset();
    wb_wdata_i = 32'h12345678;
    for (int i = 0; i < 24; i++) begin
      btn_step = (i < 10);
      @(negedge clk);
      if (cpu_ce_o === 1'b1) pulses++;
      if (cpu_ce_o !== m_ce()) model_bad++;
      if (state_o === 2'b01) seen_run++;
      adv();
    end
    @(negedge clk);
    n_checks++;
    if (pulses != 1) $display("FAIL step_pulses: got %0d want 1", pulses);
    else n_pass++;
    n_checks++;
    if (model_bad != 0 || seen_run != 0)
      $display("FAIL step_model_ce: got %0d ce mismatches, %0d run cycles, want 0", model_bad, seen_run);
    else n_pass++;
    n_checks++;
    if (instr_cnt_o !== 16'd1) $display("FAIL step_cnt: got %0d want 1", instr_cnt_o);
    else n_pass++;
    n_checks++;
    if (disp_data_o !== 32'h12345678) $display("FAIL step_disp: got %0h want 12345678", disp_data_o);
    else n_pass++;
    n_checks++;
    if (state_o !== 2'b00) $display("FAIL step_state: got %0d want 0", state_o);
    else n_pass++;
  endtask

  task automatic test_bounce();
    int entries, bad_ce;
    logic [1:0] prev;
    entries = 0; bad_ce = 0; prev = 2'b00;
    do_reset();
    for (int i = 0; i < 30; i++) begin
      btn_run = (i < 20) ? (((i / 2) % 2) == 0) : 1'b1;
      @(negedge clk);
      if (prev == 2'b00 && state_o == 2'b01) entries++;
      if (state_o == 2'b01 && cpu_ce_o !== 1'b1) bad_ce++;
      prev = state_o;
      adv();
    end
    @(negedge clk);
    n_checks++;
    if (entries != 1) $display("FAIL bounce_entries: got %0d want 1", entries);
    else n_pass++;
    n_checks++;
    if (state_o !== 2'b01) $display("FAIL bounce_state: got %0d want 1", state_o);
    else n_pass++;
    n_checks++;
    if (bad_ce != 0) $display("FAIL bounce_ce: got %0d idle run cycles want 0", bad_ce);
    else n_pass++;
    btn_run = 1'b0;
    idle(8);
    btn_run = 1'b1;
    idle(10);
    btn_run = 1'b0;
    idle(2);
    @(negedge clk);
    n_checks++;
    if (state_o !== 2'b00) $display("FAIL bounce_second_press: got %0d want 0", state_o);
    else n_pass++;
  endtask

  task automatic test_breakpoint();
    bit found;
    do_reset();
    bp_en = 1'b1; bp_addr = 32'h10; pc_track = 1; pc_i = '0;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      btn_run = (i < 10);
      @(negedge clk);
      if (state_o === 2'b01 && pc_i == 32'h10) begin
        found = 1;
        n_checks++;
        if (cpu_ce_o !== 1'b0) $display("FAIL bp_hit_ce: got %0b want 0", cpu_ce_o);
        else n_pass++;
      end
      adv();
    end
    btn_run = 1'b0;
    n_checks++;
    if (!found) $display("FAIL bp_reach: pc 0x10 in RUN not seen within 60 cycles");
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (state_o !== 2'b11) $display("FAIL bp_state: got %0d want 3", state_o);
    else n_pass++;
    n_checks++;
    if (instr_cnt_o !== 16'd4) $display("FAIL bp_cnt: got %0d want 4", instr_cnt_o);
    else n_pass++;
    n_checks++;
    if (halted_o !== 1'b1 || cpu_ce_o !== 1'b0)
      $display("FAIL bp_halted: got halted %0b ce %0b want 1 0", halted_o, cpu_ce_o);
    else n_pass++;
    idle(8);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      btn_run = (i < 10);
      @(negedge clk);
      if (state_o === 2'b01) begin
        found = 1;
        n_checks++;
        if (cpu_ce_o !== 1'b1 || pc_i !== 32'h10)
          $display("FAIL bp_resume: got ce %0b pc %0h want 1 10", cpu_ce_o, pc_i);
        else n_pass++;
      end
      adv();
    end
    btn_run = 1'b0;
    n_checks++;
    if (!found) $display("FAIL bp_resume_reach: RUN not seen within 40 cycles");
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (state_o !== 2'b01 || instr_cnt_o !== 16'd5)
      $display("FAIL bp_no_rebreak: got state %0d cnt %0d want 1 5", state_o, instr_cnt_o);
    else n_pass++;
    pc_track = 0;
  endtask

  task automatic test_simul_wrap();
    int guard;
    bit seen_step;
    guard = 0; seen_step = 0;
    do_reset();
    btn_run = 1'b1; btn_step = 1'b1;
    while (m_cnt != 16'hFFFF && guard < 70000) begin
      if (guard == 12) begin btn_run = 1'b0; btn_step = 1'b0; end
      @(negedge clk);
      if (state_o === 2'b10) seen_step = 1;
      adv();
      guard++;
    end
    btn_run = 1'b0; btn_step = 1'b0;
    n_checks++;
    if (guard >= 70000) $display("FAIL wrap_timeout: counter did not reach FFFF");
    else n_pass++;
    n_checks++;
    if (seen_step) $display("FAIL simul_step: got STEP state, want RUN only");
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (instr_cnt_o !== 16'hFFFF || cpu_ce_o !== 1'b1 || state_o !== 2'b01)
      $display("FAIL wrap_top: got cnt %0h ce %0b state %0d want ffff 1 1", instr_cnt_o, cpu_ce_o, state_o);
    else n_pass++;
    adv();
    @(negedge clk);
    n_checks++;
    if (instr_cnt_o !== 16'h0000) $display("FAIL wrap_zero: got %0h want 0", instr_cnt_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int guard, bad_state;
    guard = 0; bad_state = 0;
    do_reset();
    wb_wdata_i = 32'hCAFE0001;
    btn_run = 1'b1;
    idle(10);
    btn_run = 1'b0;
    while (m_cnt != 35 && guard < 100) begin adv(); guard++; end
    btn_run = 1'b1;
    idle(2);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (instr_cnt_o !== 16'd37 || state_o !== 2'b01)
      $display("FAIL mid_pre_cnt: got cnt %0d state %0d want 37 1", instr_cnt_o, state_o);
    else n_pass++;
    adv();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (state_o !== 2'b00 || cpu_ce_o !== 1'b0 || instr_cnt_o !== 16'd0 ||
        disp_data_o !== 32'd0 || halted_o !== 1'b1)
      $display("FAIL mid_reset: got st %0d ce %0b cnt %0d disp %0h halt %0b want 0 0 0 0 1",
               state_o, cpu_ce_o, instr_cnt_o, disp_data_o, halted_o);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (state_o !== 2'b00) bad_state++;
      adv();
    end
    n_checks++;
    if (bad_state != 0) $display("FAIL mid_held_btn: got %0d non-HALT cycles want 0", bad_state);
    else n_pass++;
    btn_run = 1'b0;
    idle(10);
    btn_run = 1'b1;
    idle(10);
    btn_run = 1'b0;
    @(negedge clk);
    n_checks++;
    if (state_o !== 2'b01) $display("FAIL mid_repress: got %0d want 1", state_o);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 4) == 0) btn_run  = ~btn_run;
      if ($urandom_range(0, 4) == 0) btn_step = ~btn_step;
      bp_en      = ($urandom_range(0, 9) < 7);
      bp_addr    = 32'($urandom_range(0, 7)) << 2;
      pc_i       = 32'($urandom_range(0, 7)) << 2;
      wb_wdata_i = $urandom;
      rst        = ($urandom_range(0, 299) == 0);
      @(negedge clk);
      n_checks++;
      if (state_o !== 2'(m_state)) $display("FAIL rnd_state cyc %0d: got %0d want %0d", i, state_o, m_state);
      else n_pass++;
      n_checks++;
      if (cpu_ce_o !== m_ce()) $display("FAIL rnd_ce cyc %0d: got %0b want %0b", i, cpu_ce_o, m_ce());
      else n_pass++;
      n_checks++;
      if (instr_cnt_o !== 16'(m_cnt)) $display("FAIL rnd_cnt cyc %0d: got %0d want %0d", i, instr_cnt_o, m_cnt);
      else n_pass++;
      n_checks++;
      if (disp_data_o !== m_disp) $display("FAIL rnd_disp cyc %0d: got %0h want %0h", i, disp_data_o, m_disp);
      else n_pass++;
      n_checks++;
      if (halted_o !== (m_state == S_HALT || m_state == S_BRK))
        $display("FAIL rnd_halted cyc %0d: got %0b state %0d", i, halted_o, m_state);
      else n_pass++;
      adv();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; btn_run = 1'b0; btn_step = 1'b0; bp_en = 1'b0;
    bp_addr = '0; pc_i = '0; wb_wdata_i = '0;
    test_reset();
    test_step();
    test_bounce();
    test_breakpoint();
    test_simul_wrap();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
